// File: rtl/tia_player_graphics_scan.sv
// Player graphics serializer: scans GRPx out one bit per count-gate advance after a start strobe.
// Optional TIA_PLAYER_MISSILE_RESET_EN adds the mrst centre-of-player pulse output.
module tia_player_graphics_scan #(
  parameter int unsigned GRP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 r,
  input  logic                 start_bar,
  input  logic                 count_bar,
  input  logic                 grp_wr,
  input  logic [GRP_WIDTH-1:0] grp_data,
  input  logic                 copy_old,
  input  logic                 vdel,
  input  logic                 refl,
`ifdef TIA_PLAYER_MISSILE_RESET_EN
  output logic                 mrst,
`endif
  output logic                 pix_out,
  output logic                 scanning
);

  localparam int unsigned IdxW = (GRP_WIDTH > 1) ? $clog2(GRP_WIDTH) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(GRP_WIDTH - 1);

  typedef enum logic {StIdle, StScan} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [GRP_WIDTH-1:0]   grp_new_q, grp_new_d;
  logic [GRP_WIDTH-1:0]   grp_old_q, grp_old_d;
  logic [GRP_WIDTH-1:0]   sel;
  logic [IdxW-1:0]        bitpos;

  always_comb begin
    grp_new_d = grp_wr ? grp_data : grp_new_q;
    // copy_old always captures the pre-edge new register, even on a simultaneous write
    grp_old_d = copy_old ? grp_new_q : grp_old_q;
    state_d   = state_q;
    idx_d     = idx_q;
    // Start (including retrigger) beats any advance on the same edge
    if (!start_bar) begin
      state_d = StScan;
      idx_d   = '0;
    end else if (state_q == StScan && !count_bar) begin
      if (idx_q == IdxLast) begin
        state_d = StIdle;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    sel      = vdel ? grp_old_q : grp_new_q;
    bitpos   = refl ? idx_q : (IdxLast - idx_q);
    scanning = (state_q == StScan);
    pix_out  = scanning & sel[bitpos];
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      grp_new_q <= '0;
      grp_old_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      grp_new_q <= grp_new_d;
      grp_old_q <= grp_old_d;
    end
  end

`ifdef TIA_PLAYER_MISSILE_RESET_EN
  localparam logic [IdxW-1:0] IdxMid = IdxW'(GRP_WIDTH / 2 - 1);

  logic mrst_q;
  logic adv_mid;

  // Only a genuine advance past the centre pixel counts; a retrigger suppresses it
  assign adv_mid = (state_q == StScan) && start_bar && !count_bar && (idx_q == IdxMid);
  assign mrst    = mrst_q;

  always_ff @(posedge clk) begin
    if (r) begin
      mrst_q <= 1'b0;
    end else begin
      mrst_q <= adv_mid;
    end
  end
`endif

endmodule

// File: tb/tb_tia_player_graphics_scan.sv
// Table-driven bench for tia_player_graphics_scan; expectations flow through a scoreboard queue.
// Checks mrst too when TIA_PLAYER_MISSILE_RESET_EN is defined.
module tb_tia_player_graphics_scan;

  logic       clk = 1'b0;
  logic       r, start_bar, count_bar, grp_wr, copy_old, vdel, refl;
  logic [7:0] grp_data;
  logic       pix_out, scanning;
`ifdef TIA_PLAYER_MISSILE_RESET_EN
  logic       mrst;
`endif

  tia_player_graphics_scan #(.GRP_WIDTH(8)) dut (
    .clk       (clk),
    .r         (r),
    .start_bar (start_bar),
    .count_bar (count_bar),
    .grp_wr    (grp_wr),
    .grp_data  (grp_data),
    .copy_old  (copy_old),
    .vdel      (vdel),
    .refl      (refl),
`ifdef TIA_PLAYER_MISSILE_RESET_EN
    .mrst      (mrst),
`endif
    .pix_out   (pix_out),
    .scanning  (scanning)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, sb, cb, wr;
    logic [7:0] data;
    logic       co, vd, rf;
    logic       pix, scan, mrst;
  } vec_t;

  typedef struct {
    int   id;
    logic pix, scan, mrst;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input logic r_, input logic sb_, input logic cb_, input logic wr_,
                     input logic [7:0] d_, input logic co_, input logic vd_, input logic rf_,
                     input logic pix_, input logic scan_, input logic mrst_);
    vec_t v;
    v.r = r_; v.sb = sb_; v.cb = cb_; v.wr = wr_; v.data = d_; v.co = co_;
    v.vd = vd_; v.rf = rf_; v.pix = pix_; v.scan = scan_; v.mrst = mrst_;
    vecs.push_back(v);
  endtask

  // bits lists displayed pixels left to right (MSB first); count gate low every period cycles
  task automatic add_scan(input logic [7:0] bits, input int period, input logic vd_,
                          input logic rf_, input bit terminal);
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, vd_, rf_, bits[7], 1'b1, 1'b0);
    for (int j = 1; j < 8 * period; j++) begin
      int   p;
      logic c;
      p = j / period;
      c = (j % period == 0) ? 1'b0 : 1'b1;
      add(1'b0, 1'b1, c, 1'b0, 8'h00, 1'b0, vd_, rf_, bits[7 - p], 1'b1, (c == 1'b0) && (p == 4));
    end
    if (terminal) add(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, vd_, rf_, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [7:0] d, input logic co);
    add(1'b0, 1'b1, 1'b1, 1'b1, d, co, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input int id, input logic got, input logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL vec%0d %s got %b want %b", id, name, got, want);
    end
  endtask

  initial begin
    exp_t e;
    logic [7:0] rb;
    r = 1'b1; start_bar = 1'b1; count_bar = 1'b1; grp_wr = 1'b0; grp_data = 8'h00;
    copy_old = 1'b0; vdel = 1'b0; refl = 1'b0;

    // Reset state, then basic scans
    add(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wr(8'hA5, 1'b0);
    add_scan(8'b10100101, 1, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wr(8'hC1, 1'b0);
    add_scan(8'b10000011, 1, 1'b0, 1'b1, 1'b1);
    wr(8'hF0, 1'b0);
    add_scan(8'b11110000, 2, 1'b0, 1'b0, 1'b1);
    add_scan(8'b11110000, 4, 1'b0, 1'b0, 1'b1);

    // Vertical delay and old/new register handoff
    wr(8'hFF, 1'b0);
    wr(8'h00, 1'b1);
    add_scan(8'hFF, 1, 1'b1, 1'b0, 1'b1);
    add_scan(8'h00, 1, 1'b0, 1'b0, 1'b1);
    wr(8'h5A, 1'b0);
    wr(8'h3C, 1'b1);
    add_scan(8'b01011010, 1, 1'b1, 1'b0, 1'b1);
    add_scan(8'b00111100, 1, 1'b0, 1'b0, 1'b1);

    // Start coinciding with the terminal advance restarts the scan
    wr(8'h81, 1'b0);
    add_scan(8'b10000001, 1, 1'b0, 1'b0, 1'b0);
    add_scan(8'b10000001, 1, 1'b0, 1'b0, 1'b1);

    // Retrigger at idx 5, then reset mid-scan
    rb = 8'b10000001;
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int j = 1; j <= 5; j++)
      add(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, rb[7 - j], 1'b1, j == 4);
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Both registers cleared by reset
    add_scan(8'h00, 1, 1'b0, 1'b0, 1'b1);
    add_scan(8'h00, 1, 1'b1, 1'b0, 1'b1);

    foreach (vecs[i]) begin
      r = vecs[i].r; start_bar = vecs[i].sb; count_bar = vecs[i].cb; grp_wr = vecs[i].wr;
      grp_data = vecs[i].data; copy_old = vecs[i].co; vdel = vecs[i].vd; refl = vecs[i].rf;
      e.id = i; e.pix = vecs[i].pix; e.scan = vecs[i].scan; e.mrst = vecs[i].mrst;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("pix_out", e.id, pix_out, e.pix);
      check("scanning", e.id, scanning, e.scan);
`ifdef TIA_PLAYER_MISSILE_RESET_EN
      check("mrst", e.id, mrst, e.mrst);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
